// File: rtl/e203_exu_alu_oitf.sv
// e203_exu_alu_oitf: outstanding-instruction tracking FIFO with register hazard lookup
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 2
`endif
module e203_exu_alu_oitf #(
  parameter int OITF_DEPTH = 4,
  parameter int ITAG_W = `E203_ITAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         dis_ready,
  input  logic                         dis_ena,
  output logic [ITAG_W-1:0]            dis_ptr,
  input  logic [`E203_RFIDX_WIDTH-1:0] dis_rdidx,
  input  logic                         dis_rdwen,
  input  logic [`E203_PC_SIZE-1:0]     dis_pc,
  input  logic                         disp_i_rs1en,
  input  logic                         disp_i_rs2en,
  input  logic                         disp_i_rdwen,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
  output logic                         oitfrd_match_disprs1,
  output logic                         oitfrd_match_disprs2,
  output logic                         oitfrd_match_disprd,
  output logic                         oitf_empty,
  output logic [ITAG_W-1:0]            oitf_ret_ptr,
  output logic [`E203_RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic [`E203_PC_SIZE-1:0]     oitf_ret_pc,
  output logic                         oitf_ret_rdwen,
  input  logic                         oitf_ret_ena
);
  // pointers carry the wrap flag in their MSB so a plain +1 toggles it on wrap
  logic [ITAG_W:0]                  alc_q, alc_d, ret_q, ret_d;
  logic [OITF_DEPTH-1:0]            vld_q, rdwen_q;
  logic [`E203_RFIDX_WIDTH-1:0]     rdidx_q [OITF_DEPTH];
  logic [`E203_PC_SIZE-1:0]         pc_q    [OITF_DEPTH];
  logic                             full, alc_fire, ret_fire;
  logic [ITAG_W-1:0]                alc_ptr, ret_ptr;

  assign alc_ptr    = alc_q[ITAG_W-1:0];
  assign ret_ptr    = ret_q[ITAG_W-1:0];
  assign oitf_empty = (alc_ptr == ret_ptr) & (alc_q[ITAG_W] == ret_q[ITAG_W]);
  assign full       = (alc_ptr == ret_ptr) & (alc_q[ITAG_W] != ret_q[ITAG_W]);
  assign dis_ready  = ~full;
  assign dis_ptr    = alc_ptr;
  assign alc_fire   = dis_ena & ~full;
  assign ret_fire   = oitf_ret_ena & ~oitf_empty;
  assign alc_d      = alc_fire ? alc_q + 1'b1 : alc_q;
  assign ret_d      = ret_fire ? ret_q + 1'b1 : ret_q;

  assign oitf_ret_ptr   = ret_ptr;
  assign oitf_ret_rdidx = rdidx_q[ret_ptr];
  assign oitf_ret_pc    = pc_q[ret_ptr];
  assign oitf_ret_rdwen = rdwen_q[ret_ptr];

  // hazard lookup over registered entries only; retiring entries still match
  always_comb begin
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      oitfrd_match_disprs1 |= disp_i_rs1en & vld_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_i_rs1idx);
      oitfrd_match_disprs2 |= disp_i_rs2en & vld_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_i_rs2idx);
      oitfrd_match_disprd  |= disp_i_rdwen & vld_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_i_rdidx);
    end
  end

  // pointer and entry state; allocate and retire never hit the same entry together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_q   <= '0;
      ret_q   <= '0;
      vld_q   <= '0;
      rdwen_q <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      alc_q <= alc_d;
      ret_q <= ret_d;
      if (alc_fire) begin
        vld_q[alc_ptr]   <= 1'b1;
        rdwen_q[alc_ptr] <= dis_rdwen;
        rdidx_q[alc_ptr] <= dis_rdidx;
        pc_q[alc_ptr]    <= dis_pc;
      end
      if (ret_fire) vld_q[ret_ptr] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_e203_exu_alu_oitf.sv
// tb_e203_exu_alu_oitf: directed self-checking bench for the OITF
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 2
`endif
module tb_e203_exu_alu_oitf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dis_ready, dis_ena;
  logic [1:0]  dis_ptr;
  logic [4:0]  dis_rdidx;
  logic        dis_rdwen;
  logic [31:0] dis_pc;
  logic        disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
  logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic        m1, m2, md;
  logic        oitf_empty;
  logic [1:0]  oitf_ret_ptr;
  logic [4:0]  oitf_ret_rdidx;
  logic [31:0] oitf_ret_pc;
  logic        oitf_ret_rdwen, oitf_ret_ena;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_exu_alu_oitf #(.OITF_DEPTH(4), .ITAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ready(dis_ready), .dis_ena(dis_ena), .dis_ptr(dis_ptr),
    .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_pc(dis_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rdwen(disp_i_rdwen),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rdidx(disp_i_rdidx),
    .oitfrd_match_disprs1(m1), .oitfrd_match_disprs2(m2), .oitfrd_match_disprd(md),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_pc(oitf_ret_pc), .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_ena(oitf_ret_ena)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic wen, input logic [31:0] pc);
    dis_ena = 1'b1; dis_rdidx = rd; dis_rdwen = wen; dis_pc = pc;
  endtask

  initial begin
    rst_n = 1'b0; dis_ena = 1'b0; dis_rdidx = '0; dis_rdwen = 1'b0; dis_pc = '0;
    disp_i_rs1en = 1'b1; disp_i_rs2en = 1'b1; disp_i_rdwen = 1'b1;
    disp_i_rs1idx = '0; disp_i_rs2idx = '0; disp_i_rdidx = '0; oitf_ret_ena = 1'b0;
    step(); step();
    #1;
    chk("rst_empty", oitf_empty, 1);
    chk("rst_ready", dis_ready, 1);
    chk("rst_dis_ptr", dis_ptr, 0);
    chk("rst_ret_ptr", oitf_ret_ptr, 0);
    chk("rst_ret_rdidx", oitf_ret_rdidx, 0);
    chk("rst_ret_pc", oitf_ret_pc, 0);
    chk("rst_ret_rdwen", oitf_ret_rdwen, 0);
    chk("rst_matches", {m1, m2, md}, 0);
    rst_n = 1'b1;
    step();
    // fill all four entries
    for (int i = 0; i < 4; i++) begin
      dispatch(5'(5 + i), 1'b1, 32'h100 + 32'(4 * i));
      #1 chk($sformatf("fill_dis_ptr%0d", i), dis_ptr, i);
      chk($sformatf("fill_ready%0d", i), dis_ready, 1);
      step();
    end
    dis_ena = 1'b0;
    #1 chk("full_ready", dis_ready, 0);
    chk("full_empty", oitf_empty, 0);
    dispatch(5'd9, 1'b1, 32'h200);
    step();
    dis_ena = 1'b0;
    #1 chk("full_ignore_ready", dis_ready, 0);
    chk("full_ignore_ret_ptr", oitf_ret_ptr, 0);
    chk("full_ignore_rdidx", oitf_ret_rdidx, 5);
    chk("full_ignore_pc", oitf_ret_pc, 32'h100);
    chk("full_dis_ptr", dis_ptr, 0);
    // retire and attempted allocate while full
    dispatch(5'd9, 1'b1, 32'h200);
    oitf_ret_ena = 1'b1;
    step();
    dis_ena = 1'b0; oitf_ret_ena = 1'b0;
    #1 chk("ret_full_ready", dis_ready, 1);
    chk("ret_full_ret_ptr", oitf_ret_ptr, 1);
    chk("ret_full_rdidx", oitf_ret_rdidx, 6);
    chk("ret_full_dis_ptr", dis_ptr, 0);
    chk("ret_full_no9", {m1, m2, md}, 0);
    // entry 0 gets rdidx 12 with rdwen=0; entries 1..3 hold 6,7,8 writing
    dispatch(5'd12, 1'b0, 32'h300);
    step();
    dis_ena = 1'b0;
    disp_i_rs1idx = 5'd7; disp_i_rs2idx = 5'd12; disp_i_rdidx = 5'd8;
    #1 chk("haz_rs1_hit", m1, 1);
    chk("haz_rs2_nowen", m2, 0);
    chk("haz_rd_hit", md, 1);
    disp_i_rs1en = 1'b0; disp_i_rdidx = 5'd9;
    #1 chk("haz_rs1_disabled", m1, 0);
    chk("haz_rd_miss", md, 0);
    disp_i_rs1en = 1'b1;
    // retire the four entries in order, checking the oldest-entry view
    oitf_ret_ena = 1'b1;
    #1 chk("drain0_rdidx", oitf_ret_rdidx, 6);
    chk("drain0_rdwen", oitf_ret_rdwen, 1);
    step();
    #1 chk("drain1_rdidx", oitf_ret_rdidx, 7);
    chk("drain1_retiring_match", m1, 1);
    step();
    #1 chk("drain2_rdidx", oitf_ret_rdidx, 8);
    chk("drain2_rs1_gone", m1, 0);
    step();
    #1 chk("drain3_rdidx", oitf_ret_rdidx, 12);
    chk("drain3_rdwen", oitf_ret_rdwen, 0);
    chk("drain3_pc", oitf_ret_pc, 32'h300);
    step();
    #1 chk("drained_empty", oitf_empty, 1);
    chk("drained_ret_ptr", oitf_ret_ptr, 1);
    step();
    oitf_ret_ena = 1'b0;
    #1 chk("empty_ret_ignored_empty", oitf_empty, 1);
    chk("empty_ret_ignored_ptr", oitf_ret_ptr, 1);
    chk("empty_dis_ptr", dis_ptr, 1);
    // new allocation is not visible to the hazard check until the next cycle
    disp_i_rs1idx = 5'd20;
    dispatch(5'd20, 1'b1, 32'h400);
    oitf_ret_ena = 1'b1;
    #1 chk("alloc_same_cycle_nomatch", m1, 0);
    step();
    dis_ena = 1'b0; oitf_ret_ena = 1'b0;
    #1 chk("alloc_next_cycle_match", m1, 1);
    chk("alloc_while_empty_ptr", oitf_ret_ptr, 1);
    chk("alloc_while_empty_rdidx", oitf_ret_rdidx, 20);
    // ten allocate/retire pairs at occupancy one
    for (int k = 0; k < 10; k++) begin
      dispatch(5'(21 + k), 1'b1, 32'h500 + 32'(k));
      oitf_ret_ena = 1'b1;
      #1 chk($sformatf("pair%0d_ret_ptr", k), oitf_ret_ptr, (1 + k) % 4);
      chk($sformatf("pair%0d_rdidx", k), oitf_ret_rdidx, (k == 0) ? 20 : 20 + k);
      chk($sformatf("pair%0d_empty", k), oitf_empty, 0);
      step();
    end
    dis_ena = 1'b0;
    #1 chk("pairs_ret_ptr", oitf_ret_ptr, 3);
    chk("pairs_last_rdidx", oitf_ret_rdidx, 30);
    step();
    oitf_ret_ena = 1'b0;
    #1 chk("pairs_final_empty", oitf_empty, 1);
    chk("pairs_dis_ptr", dis_ptr, 0);
    // three entries then an asynchronous reset pulse between edges
    for (int i = 0; i < 3; i++) begin
      dispatch(5'(3 + i), 1'b1, 32'h600 + 32'(i));
      step();
    end
    dis_ena = 1'b0;
    disp_i_rs1idx = 5'd3; disp_i_rs2idx = 5'd4; disp_i_rdidx = 5'd5;
    #1 chk("pre_rst_match", {m1, m2, md}, 3'b111);
    chk("pre_rst_empty", oitf_empty, 0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_empty", oitf_empty, 1);
    chk("async_rst_ready", dis_ready, 1);
    chk("async_rst_dis_ptr", dis_ptr, 0);
    chk("async_rst_ret_ptr", oitf_ret_ptr, 0);
    chk("async_rst_rdidx", oitf_ret_rdidx, 0);
    chk("async_rst_pc", oitf_ret_pc, 0);
    chk("async_rst_matches", {m1, m2, md}, 0);
    #1 rst_n = 1'b1;
    dispatch(5'd17, 1'b1, 32'h700);
    #1 chk("post_rst_dis_ptr", dis_ptr, 0);
    step();
    dis_ena = 1'b0;
    #1 chk("post_rst_rdidx", oitf_ret_rdidx, 17);
    chk("post_rst_pc", oitf_ret_pc, 32'h700);
    chk("post_rst_dis_ptr_next", dis_ptr, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
